mate_scanner: RTL and testbench
===============================

Name: mate_scanner

Overview:
Parametrised end-of-game detector for the side to move. On `start`, it walks every board square in index order. For each square holding a piece of the side to move, it asks the move-generator block (one request per square) for that piece's legal-move bitmap. It accumulates the legal moves found and reports the outcome: checkmate, stalemate, game continues, or generator timeout. It sits between the turn controller and the move generator.

Parameters:
BOARD_W, 8, board width in squares
BOARD_H, 8, board height in squares
PIECE_BITS, 4, bits per square in board_data; MSB = colour (0 white, 1 black); all-zero = empty
COUNT_MODE, 0, 0 = stop at first piece with a legal move; 1 = scan all squares and count every legal move
GEN_TIMEOUT, 255, max cycles to wait for gen_ready per request; 0 = no timeout
(derived) N = BOARD_W*BOARD_H, IDXW = $clog2(N), CNTW = $clog2(N*N+1)

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous, active-high; returns block to IDLE
start  in  1  begin scan; honoured only in IDLE or DONE
turn  in  1  side to move (0 white, 1 black); latched on accepted start
in_check  in  1  side to move is currently in check; latched on accepted start
board_data  in  N*PIECE_BITS  square s occupies bits [s*PIECE_BITS +: PIECE_BITS]; held stable by upstream while busy
move_options  in  N  legal-destination bitmap from generator; valid while gen_ready=1
gen_ready  in  1  generator result valid
sel_pos  out  IDXW  square currently being examined or requested
gen_req  out  1  one-cycle request to generator for piece at sel_pos
ready  out  1  high in IDLE and DONE
done  out  1  one-cycle pulse on entry to DONE
result  out  2  00 game continues, 01 checkmate, 10 stalemate, 11 generator timeout
legal_count  out  CNTW  legal moves accumulated in this scan (saturating)

Behaviour:
- Reset (async): state=IDLE, sel_pos=0, gen_req=0, ready=1, done=0, result=00, legal_count=0, timeout counter=0.
- States: IDLE, TEST, REQ, WAIT, EVAL, NEXT, DONE.
- IDLE/DONE, start=1: latch turn and in_check; sel_pos=0; legal_count=0; result=00; ready=0; go to TEST. start in any other state is ignored.
- TEST: piece = board_data[sel_pos]. If nonzero and colour bit == latched turn, go to REQ. Otherwise, go to DONE if sel_pos==N-1, else go to NEXT.
- REQ: gen_req=1 for exactly this cycle; clear timeout counter; go to WAIT. A gen_ready seen in the REQ cycle is ignored.
- WAIT: gen_req=0. gen_ready=1 goes to EVAL, capturing move_options that cycle. Otherwise increment the timeout counter. If GEN_TIMEOUT!=0 and the counter reaches GEN_TIMEOUT: result=11, go to DONE.
- EVAL: legal_count += popcount(captured options), saturating at 2^CNTW-1.
  - COUNT_MODE=0 and popcount>0: result=00, go to DONE.
  - Otherwise, if sel_pos==N-1, go to DONE; else go to NEXT.
- NEXT: sel_pos += 1; go to TEST. sel_pos never wraps during a scan.
- Final result, when the scan finishes without timeout:
  - legal_count>0: 00
  - legal_count==0 and in_check: 01
  - legal_count==0 and not in_check: 10
- DONE: done=1 on the first cycle only; ready=1. result, legal_count and sel_pos hold until the next accepted start. Start in DONE restarts immediately; done does not re-pulse until the next DONE entry.
- Per-square latency, from a TEST cycle with no request: 2 cycles (TEST→NEXT→TEST).
- Per-square latency, requested square: 4 cycles + generator wait.
- Reset asserted mid-scan aborts immediately; gen_req drops asynchronously.
- The board is not snapshotted; changing board_data mid-scan is a protocol violation with undefined result.

Decomposition:
- Shared package chess_pkg holds:
  - colour constants WHITE/BLACK;
  - EMPTY piece code;
  - result encodings RES_NONE/RES_MATE/RES_STALE/RES_TIMEOUT;
  - PIECE_BITS default.
- One sub-module, popcount_n (parametrised width N, output CNTW), computes the move count combinationally.
- State encoding is a localparam inside mate_scanner.

Test Plan:
- Empty board except one white king, turn=0, in_check=0, generator returns 0 → gen_req exactly once (sel_pos=king square); result=10; legal_count=0; done pulses once.
- Same board, in_check=1 → result=01 after one request.
- COUNT_MODE=0; white pieces on squares 3 and 10; generator returns 0 then 0x5 → two requests; result=00; legal_count=2; scan stops at sel_pos=10.
- COUNT_MODE=1; white pieces on squares 0, 1, 63, each returning 3 bits set → three requests; legal_count=9; final sel_pos=63; result=00.
- GEN_TIMEOUT=4, gen_ready held low → result=11 and done pulse exactly 4 cycles after WAIT entry; next start rescans from 0.
- Reset asserted during WAIT → gen_req=0, ready=1, result=00 with no clock edge required; start after reset runs a clean scan; black pieces ignored when turn=0.

Source files
------------

// File: rtl/chess_pkg.sv
// Shared chess encodings: colours, empty-square code and scanner result codes.
package chess_pkg;

    localparam int unsigned DEFAULT_PIECE_BITS = 4;

    localparam logic WHITE = 1'b0;
    localparam logic BLACK = 1'b1;

    localparam logic [DEFAULT_PIECE_BITS-1:0] EMPTY = '0;

    localparam logic [1:0] RES_NONE    = 2'b00;
    localparam logic [1:0] RES_MATE    = 2'b01;
    localparam logic [1:0] RES_STALE   = 2'b10;
    localparam logic [1:0] RES_TIMEOUT = 2'b11;

endpackage

// File: rtl/mate_scanner_if.sv
// Turn-controller / move-generator bus of the mate scanner.
import chess_pkg::*;

interface mate_scanner_if #(
    parameter int unsigned BOARD_W    = 8,
    parameter int unsigned BOARD_H    = 8,
    parameter int unsigned PIECE_BITS = DEFAULT_PIECE_BITS
);
    localparam int unsigned N    = BOARD_W * BOARD_H;
    localparam int unsigned IDXW = $clog2(N);
    localparam int unsigned CNTW = $clog2(N * N + 1);

    logic                    start;
    logic                    turn;
    logic                    in_check;
    logic [N*PIECE_BITS-1:0] board_data;
    logic [N-1:0]            move_options;
    logic                    gen_ready;
    logic [IDXW-1:0]         sel_pos;
    logic                    gen_req;
    logic                    ready;
    logic                    done;
    logic [1:0]              result;
    logic [CNTW-1:0]         legal_count;

    modport master (
        output start, turn, in_check, board_data, move_options, gen_ready,
        input  sel_pos, gen_req, ready, done, result, legal_count
    );

    modport slave (
        input  start, turn, in_check, board_data, move_options, gen_ready,
        output sel_pos, gen_req, ready, done, result, legal_count
    );

endinterface

// File: rtl/popcount_n.sv
// Combinational population count of an N-bit vector.
module popcount_n #(
    parameter int unsigned N    = 64,
    parameter int unsigned CNTW = 13
) (
    input  logic [N-1:0]    bits,
    output logic [CNTW-1:0] count
);

    always_comb begin
        count = '0;
        for (int i = 0; i < N; i++) begin
            count = count + CNTW'(bits[i]);
        end
    end

endmodule

// File: rtl/mate_scanner.sv
// End-of-game detector: walks the board, queries the move generator for each
// piece of the side to move and classifies the position.
import chess_pkg::*;

module mate_scanner #(
    parameter int unsigned BOARD_W     = 8,
    parameter int unsigned BOARD_H     = 8,
    parameter int unsigned PIECE_BITS  = DEFAULT_PIECE_BITS,
    parameter int unsigned COUNT_MODE  = 0,
    parameter int unsigned GEN_TIMEOUT = 255
) (
    input  logic           clk,
    input  logic           reset,
    mate_scanner_if.slave  bus
);

    localparam int unsigned N    = BOARD_W * BOARD_H;
    localparam int unsigned IDXW = $clog2(N);
    localparam int unsigned CNTW = $clog2(N * N + 1);
    localparam int unsigned DW   = N * PIECE_BITS;
    localparam int unsigned SW   = $clog2(DW);
    localparam int unsigned TW   = (GEN_TIMEOUT > 0) ? $clog2(GEN_TIMEOUT + 1) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_TEST,
        S_REQ,
        S_WAIT,
        S_EVAL,
        S_NEXT,
        S_DONE
    } state_e;

    state_e          state;
    logic            side;
    logic            check_l;
    logic [N-1:0]    opts;
    logic [TW-1:0]   tmo;

    logic [CNTW-1:0]       pc_c;
    logic [CNTW:0]         sum_c;
    logic [CNTW-1:0]       count_next_c;
    logic [SW-1:0]         bit_idx_c;
    logic [PIECE_BITS-1:0] piece_c;
    logic                  own_c;
    logic                  last_c;
    logic [TW-1:0]         tmo_inc_c;

    popcount_n #(
        .N    (N),
        .CNTW (CNTW)
    ) u_popcount (
        .bits  (opts),
        .count (pc_c)
    );

    function automatic logic [1:0] final_res(input logic [CNTW-1:0] cnt, input logic chk);
        if (cnt != '0) return RES_NONE;
        if (chk)       return RES_MATE;
        return RES_STALE;
    endfunction

    // Square decode, saturating move accumulation and timeout increment.
    always_comb begin
        bit_idx_c    = SW'(bus.sel_pos) * SW'(PIECE_BITS);
        piece_c      = bus.board_data[bit_idx_c +: PIECE_BITS];
        own_c        = (piece_c != PIECE_BITS'(EMPTY)) && (piece_c[PIECE_BITS-1] == side);
        last_c       = (bus.sel_pos == IDXW'(N - 1));
        sum_c        = {1'b0, bus.legal_count} + {1'b0, pc_c};
        count_next_c = sum_c[CNTW] ? '1 : sum_c[CNTW-1:0];
        tmo_inc_c    = tmo + TW'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= S_IDLE;
            side            <= WHITE;
            check_l         <= 1'b0;
            opts            <= '0;
            tmo             <= '0;
            bus.sel_pos     <= '0;
            bus.gen_req     <= 1'b0;
            bus.ready       <= 1'b1;
            bus.done        <= 1'b0;
            bus.result      <= RES_NONE;
            bus.legal_count <= '0;
        end else begin
            bus.gen_req <= 1'b0;
            bus.done    <= 1'b0;
            case (state)
                S_IDLE, S_DONE: begin
                    if (bus.start) begin
                        side            <= bus.turn;
                        check_l         <= bus.in_check;
                        bus.sel_pos     <= '0;
                        bus.legal_count <= '0;
                        bus.result      <= RES_NONE;
                        bus.ready       <= 1'b0;
                        state           <= S_TEST;
                    end
                end
                S_TEST: begin
                    if (own_c) begin
                        bus.gen_req <= 1'b1;
                        state       <= S_REQ;
                    end else if (last_c) begin
                        bus.result <= final_res(bus.legal_count, check_l);
                        bus.done   <= 1'b1;
                        bus.ready  <= 1'b1;
                        state      <= S_DONE;
                    end else begin
                        state <= S_NEXT;
                    end
                end
                S_REQ: begin
                    tmo   <= '0;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (bus.gen_ready) begin
                        opts  <= bus.move_options;
                        state <= S_EVAL;
                    end else begin
                        tmo <= tmo_inc_c;
                        if (GEN_TIMEOUT != 0 && tmo_inc_c == TW'(GEN_TIMEOUT)) begin
                            bus.result <= RES_TIMEOUT;
                            bus.done   <= 1'b1;
                            bus.ready  <= 1'b1;
                            state      <= S_DONE;
                        end
                    end
                end
                S_EVAL: begin
                    bus.legal_count <= count_next_c;
                    // In first-move mode any legal move settles the game as ongoing.
                    if (COUNT_MODE == 0 && pc_c != '0) begin
                        bus.result <= RES_NONE;
                        bus.done   <= 1'b1;
                        bus.ready  <= 1'b1;
                        state      <= S_DONE;
                    end else if (last_c) begin
                        bus.result <= final_res(count_next_c, check_l);
                        bus.done   <= 1'b1;
                        bus.ready  <= 1'b1;
                        state      <= S_DONE;
                    end else begin
                        state <= S_NEXT;
                    end
                end
                S_NEXT: begin
                    bus.sel_pos <= bus.sel_pos + IDXW'(1);
                    state       <= S_TEST;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mate_scanner.sv
// Directed bench for mate_scanner: one first-move/short-timeout instance and
// one count-all instance sharing clock and reset.
import chess_pkg::*;

module tb_mate_scanner;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mate_scanner_if ba ();
    mate_scanner_if bb ();

    mate_scanner #(.COUNT_MODE(0), .GEN_TIMEOUT(4)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (ba.slave)
    );

    mate_scanner #(.COUNT_MODE(1), .GEN_TIMEOUT(255)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bb.slave)
    );

    int checks   = 0;
    int failures = 0;
    int req_a = 0, done_a = 0, req_b = 0, done_b = 0;
    int req0, done0;

    always @(negedge clk) begin
        if (ba.gen_req === 1'b1) req_a++;
        if (ba.done === 1'b1)    done_a++;
        if (bb.gen_req === 1'b1) req_b++;
        if (bb.done === 1'b1)    done_b++;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] place(input logic [255:0] b, input int sq, input logic [3:0] code);
        logic [255:0] r;
        r = b;
        r[sq*4 +: 4] = code;
        return r;
    endfunction

    // Caller is at a negedge; returns at the negedge after start was accepted.
    task automatic start_scan(input int which, input logic [255:0] board, input logic t, input logic chk_in);
        if (which == 0) begin
            ba.board_data = board; ba.turn = t; ba.in_check = chk_in; ba.start = 1'b1;
        end else begin
            bb.board_data = board; bb.turn = t; bb.in_check = chk_in; bb.start = 1'b1;
        end
        @(negedge clk);
        ba.start = 1'b0;
        bb.start = 1'b0;
    endtask

    task automatic wait_req(input int which, input string tag, input int sq);
        int n;
        logic r;
        n = 0;
        r = (which == 0) ? ba.gen_req : bb.gen_req;
        while (r !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
            r = (which == 0) ? ba.gen_req : bb.gen_req;
        end
        chk({tag, "_req_seen"}, 64'(r), 64'd1);
        chk({tag, "_req_sq"}, 64'((which == 0) ? ba.sel_pos : bb.sel_pos), 64'(sq));
    endtask

    // Answers the pending request after dly idle WAIT cycles.
    task automatic serve(input int which, input string tag, input int sq, input logic [63:0] opts, input int dly);
        wait_req(which, tag, sq);
        @(negedge clk);
        chk({tag, "_req_1cyc"}, 64'((which == 0) ? ba.gen_req : bb.gen_req), 64'd0);
        repeat (dly) @(negedge clk);
        if (which == 0) begin ba.move_options = opts; ba.gen_ready = 1'b1; end
        else            begin bb.move_options = opts; bb.gen_ready = 1'b1; end
        @(negedge clk);
        ba.gen_ready = 1'b0; ba.move_options = '0;
        bb.gen_ready = 1'b0; bb.move_options = '0;
    endtask

    task automatic wait_done(input int which, input string tag);
        int n;
        logic d;
        n = 0;
        d = (which == 0) ? ba.done : bb.done;
        while (d !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
            d = (which == 0) ? ba.done : bb.done;
        end
        chk({tag, "_done_seen"}, 64'(d), 64'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    logic [255:0] brd;

    initial begin
        reset = 1'b1;
        ba.start = 0; ba.turn = 0; ba.in_check = 0; ba.board_data = '0; ba.move_options = '0; ba.gen_ready = 0;
        bb.start = 0; bb.turn = 0; bb.in_check = 0; bb.board_data = '0; bb.move_options = '0; bb.gen_ready = 0;
        #1;
        chk("rst_ready_a", 64'(ba.ready), 64'd1);
        chk("rst_done_a", 64'(ba.done), 64'd0);
        chk("rst_req_a", 64'(ba.gen_req), 64'd0);
        chk("rst_result_a", 64'(ba.result), 64'(RES_NONE));
        chk("rst_count_a", 64'(ba.legal_count), 64'd0);
        chk("rst_sel_b", 64'(bb.sel_pos), 64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Lone white king on square 4, not in check, no moves: stalemate.
        brd = place('0, 4, 4'h6);
        req0 = req_a; done0 = done_a;
        start_scan(0, brd, WHITE, 1'b0);
        chk("t1_ready_busy", 64'(ba.ready), 64'd0);
        chk("t1_sel_start", 64'(ba.sel_pos), 64'd0);
        serve(0, "t1", 4, 64'h0, 0);
        wait_done(0, "t1");
        chk("t1_result", 64'(ba.result), 64'(RES_STALE));
        chk("t1_count", 64'(ba.legal_count), 64'd0);
        chk("t1_sel_end", 64'(ba.sel_pos), 64'd63);
        chk("t1_ready_done", 64'(ba.ready), 64'd1);
        @(negedge clk);
        chk("t1_done_pulse", 64'(ba.done), 64'd0);
        chk("t1_req_count", 64'(req_a - req0), 64'd1);
        chk("t1_done_count", 64'(done_a - done0), 64'd1);

        // Same board, in check: checkmate.
        req0 = req_a;
        start_scan(0, brd, WHITE, 1'b1);
        serve(0, "t2", 4, 64'h0, 1);
        wait_done(0, "t2");
        chk("t2_result", 64'(ba.result), 64'(RES_MATE));
        chk("t2_req_count", 64'(req_a - req0), 64'd1);
        @(negedge clk);

        // First-move mode: square 3 has no moves, square 10 has two.
        brd = place(place('0, 3, 4'h2), 10, 4'h3);
        req0 = req_a;
        start_scan(0, brd, WHITE, 1'b1);
        serve(0, "t3a", 3, 64'h0, 2);
        serve(0, "t3b", 10, 64'h5, 0);
        wait_done(0, "t3");
        chk("t3_result", 64'(ba.result), 64'(RES_NONE));
        chk("t3_count", 64'(ba.legal_count), 64'd2);
        chk("t3_sel_stop", 64'(ba.sel_pos), 64'd10);
        chk("t3_req_count", 64'(req_a - req0), 64'd2);
        @(negedge clk);

        // Count-all mode: pieces on 0, 1, 63 with three moves each; black on 5 ignored.
        brd = place(place(place(place('0, 0, 4'h1), 1, 4'h2), 63, 4'h3), 5, 4'h9);
        req0 = req_b; done0 = done_b;
        start_scan(1, brd, WHITE, 1'b0);
        serve(1, "t4a", 0, 64'h7, 0);
        serve(1, "t4b", 1, 64'h70, 3);
        serve(1, "t4c", 63, 64'hC000_0000_0000_0001, 1);
        wait_done(1, "t4");
        chk("t4_count", 64'(bb.legal_count), 64'd9);
        chk("t4_sel_end", 64'(bb.sel_pos), 64'd63);
        chk("t4_result", 64'(bb.result), 64'(RES_NONE));
        chk("t4_req_count", 64'(req_b - req0), 64'd3);
        @(negedge clk);
        chk("t4_done_count", 64'(done_b - done0), 64'd1);

        // Generator never answers: timeout four cycles after WAIT entry.
        brd = place('0, 4, 4'h6);
        start_scan(0, brd, WHITE, 1'b0);
        wait_req(0, "t5", 4);
        repeat (4) @(negedge clk);
        chk("t5_done_early", 64'(ba.done), 64'd0);
        @(negedge clk);
        chk("t5_done_at4", 64'(ba.done), 64'd1);
        chk("t5_result", 64'(ba.result), 64'(RES_TIMEOUT));
        start_scan(0, brd, WHITE, 1'b0);
        chk("t5_rescan_sel", 64'(ba.sel_pos), 64'd0);
        chk("t5_rescan_result", 64'(ba.result), 64'(RES_NONE));
        serve(0, "t5r", 4, 64'h0, 0);
        wait_done(0, "t5r");
        chk("t5r_result", 64'(ba.result), 64'(RES_STALE));
        @(negedge clk);

        // Reset during the request cycle, then a clean scan; black on 2 ignored.
        brd = place(place('0, 2, 4'hE), 6, 4'h1);
        start_scan(0, brd, WHITE, 1'b0);
        wait_req(0, "t6", 6);
        #1 reset = 1'b1;
        #1;
        chk("t6_rst_req", 64'(ba.gen_req), 64'd0);
        chk("t6_rst_ready", 64'(ba.ready), 64'd1);
        chk("t6_rst_result", 64'(ba.result), 64'(RES_NONE));
        chk("t6_rst_sel", 64'(ba.sel_pos), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        req0 = req_a;
        start_scan(0, brd, WHITE, 1'b0);
        serve(0, "t6c", 6, 64'h3, 1);
        wait_done(0, "t6c");
        chk("t6_result", 64'(ba.result), 64'(RES_NONE));
        chk("t6_count", 64'(ba.legal_count), 64'd2);
        chk("t6_sel", 64'(ba.sel_pos), 64'd6);
        chk("t6_req_count", 64'(req_a - req0), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
